// File: rtl/memory_pkg.sv
// Shared definitions for the load path: default queue depth, pointer-width
// derivation and the request-register state encoding.
package memory_pkg;

    localparam int QUEUE_DEPTH_DEFAULT = 4;

    // Pointer width for a power-of-two queue; never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic {
        REQ_EMPTY = 1'b0,
        REQ_HELD  = 1'b1
    } reqState_t;

endpackage

// File: rtl/load_tag_fifo.sv
// In-order FIFO of destination-register tags for loads that are waiting for
// their memory response. The count doubles as the outstanding-load counter.
module load_tag_fifo
    import memory_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    sync_rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        pushData,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [ptrWidth(DEPTH):0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTRW = ptrWidth(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULLCOUNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    // Status flags; overflow/underflow requests are dropped so the count stays in range.
    always_comb begin
        full   = (count == FULLCOUNT);
        empty  = (count == '0);
        doPush = push && !full;
        doPop  = pop && !empty;
        head   = mem[rdPtr];
    end

    // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Tag storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/load_return_unit.sv
// Load return unit: accepts load requests, forwards the address to memory
// through a one-entry request register, remembers destination tags in order,
// and writes each in-order response back to the register file one cycle later.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high in an active (clk_en=1) cycle. A source holding valid keeps its payload
// stable until that transfer; valid never depends combinationally on ready.
module load_return_unit
    import memory_pkg::*;
#(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int QUEUEDEPTH      = QUEUE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         sync_rst_n,
    input  logic                         clk_en,
    input  logic                         Load_Req_Valid,
    output logic                         Load_Req_Ready,
    input  logic [DATABITWIDTH-1:0]      Load_Req_Address,
    input  logic [REGADDRBITWIDTH-1:0]   Load_Req_DestReg,
    output logic                         Mem_Req_Valid,
    input  logic                         Mem_Req_Ready,
    output logic [DATABITWIDTH-1:0]      Mem_Req_Address,
    input  logic                         Mem_Resp_Valid,
    input  logic [DATABITWIDTH-1:0]      Mem_Resp_Data,
    output logic                         Dirty_Set,
    output logic                         Mem_Write_En,
    output logic [REGADDRBITWIDTH-1:0]   Mem_Write_Address,
    output logic [DATABITWIDTH-1:0]      Mem_Write_Data,
    output logic                         Loads_Idle,
    output logic                         Protocol_Error,
    output logic                         Dbg_ReqState,
    output logic [ptrWidth(QUEUEDEPTH):0] Dbg_Outstanding
);

    reqState_t                     reqState;
    reqState_t                     reqStateNext;
    logic [DATABITWIDTH-1:0]       reqAddr;
    logic                          accept;
    logic                          reqFire;
    logic                          respActive;
    logic                          respPop;
    logic                          respOrphan;
    logic                          writeHit;
    logic [REGADDRBITWIDTH-1:0]    headTag;
    logic [ptrWidth(QUEUEDEPTH):0] outstanding;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic                          writeEnReg;
    logic [REGADDRBITWIDTH-1:0]    writeAddrReg;
    logic [DATABITWIDTH-1:0]       writeDataReg;
    logic                          errorReg;

    load_tag_fifo #(
        .WIDTH (REGADDRBITWIDTH),
        .DEPTH (QUEUEDEPTH)
    ) u_tagFifo (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .push       (accept),
        .pushData   (Load_Req_DestReg),
        .pop        (respPop),
        .head       (headTag),
        .count      (outstanding),
        .full       (fifoFull),
        .empty      (fifoEmpty)
    );

    // Handshake decode; ready only sees the current occupancy, a pop this cycle does not free a slot early.
    always_comb begin
        respActive     = clk_en && Mem_Resp_Valid;
        respPop        = respActive && !fifoEmpty;
        respOrphan     = respActive && fifoEmpty;
        writeHit       = respPop && (headTag != '0);
        reqFire        = clk_en && (reqState == REQ_HELD) && Mem_Req_Ready;
        Load_Req_Ready = sync_rst_n && clk_en && !fifoFull
                         && ((reqState == REQ_EMPTY) || Mem_Req_Ready);
        accept         = Load_Req_Valid && Load_Req_Ready;
    end

    // Request-register FSM: state register.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) reqState <= REQ_EMPTY;
        else             reqState <= reqStateNext;
    end

    // Request-register FSM: next state. An accept while HELD implies the old request left this cycle.
    always_comb begin
        reqStateNext = reqState;
        case (reqState)
            REQ_EMPTY: if (accept) reqStateNext = REQ_HELD;
            REQ_HELD:  if (reqFire && !accept) reqStateNext = REQ_EMPTY;
            default:   reqStateNext = REQ_EMPTY;
        endcase
    end

    // Request-register FSM: outputs. Everything is forced quiet while reset is asserted.
    always_comb begin
        Mem_Req_Valid   = sync_rst_n && (reqState == REQ_HELD);
        Mem_Req_Address = Mem_Req_Valid ? reqAddr : '0;
        Dirty_Set       = accept;
        Dbg_ReqState    = sync_rst_n && (reqState == REQ_HELD);
    end

    // Request address captured on accept and held until the memory takes it.
    always_ff @(posedge clk) begin
        if (!sync_rst_n)  reqAddr <= '0;
        else if (accept)  reqAddr <= Load_Req_Address;
    end

    // Write-back register: one-cycle pulse per popped response; tag 0 is a discard target.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            writeEnReg   <= 1'b0;
            writeAddrReg <= '0;
            writeDataReg <= '0;
        end else begin
            writeEnReg <= writeHit;
            if (writeHit) begin
                writeAddrReg <= headTag;
                writeDataReg <= Mem_Resp_Data;
            end
        end
    end

    // Sticky flag for a response that arrived with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!sync_rst_n)     errorReg <= 1'b0;
        else if (respOrphan) errorReg <= 1'b1;
    end

    // Register-file and status outputs.
    always_comb begin
        Mem_Write_En      = sync_rst_n && writeEnReg;
        Mem_Write_Address = sync_rst_n ? writeAddrReg : '0;
        Mem_Write_Data    = sync_rst_n ? writeDataReg : '0;
        Protocol_Error    = sync_rst_n && errorReg;
        Loads_Idle        = !sync_rst_n
                            || ((outstanding == '0) && (reqState == REQ_EMPTY) && !writeEnReg);
        Dbg_Outstanding   = sync_rst_n ? outstanding : '0;
    end

endmodule
